mem_req_sequencer: RTL and testbench

- Upstream request stage for the single-port memory: buffers read/write requests from a client and issues them one at a time on the memory's op/addr/data_in bus.
- Requests arrive on a valid/ready handshake into a small FIFO; an FSM pops them, issues them to memory, and returns read data as a one-cycle response pulse.
- Lets clients issue bursts without tracking memory timing.

---
 rtl/mem_req_sequencer.sv | 162 ++++++++++++++++
 tb/tb_mem_req_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_sequencer.sv
// Request sequencer for a single-port memory: a small FIFO feeds a three-state
// issue FSM that drives the memory bus and returns read data as one-cycle responses.
module mem_req_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int DEPTH      = 4,
   parameter int RD_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_op,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   output logic                    mem_en,
   output logic                    mem_op,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_data_in,
   input  logic [DATA_WIDTH-1:0]   mem_data_out,
   output logic                    rsp_valid,
   output logic [ADDR_WIDTH-1:0]   rsp_addr,
   output logic [DATA_WIDTH-1:0]   rsp_data,
   output logic [$clog2(DEPTH):0]  count,
   output logic [1:0]              dbg_state
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;
   localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_RD = 2'd2
   } state_t;

   // Handshake: a request is taken on a rising edge where req_valid && req_ready;
   // req_ready depends only on occupancy, so a full FIFO never accepts even if it pops.

   state_t state, next_state;

   logic [EW-1:0]  fifo_mem [DEPTH];
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic           full, empty, push, pop;
   logic [EW-1:0]  head;
   logic           op_r;
   logic [LW-1:0]  lat_cnt;
   logic           lat_load, rd_done;

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign req_ready = ~full;
   assign push      = req_valid & ~full;
   assign head      = fifo_mem[rd_ptr];

   assign mem_en    = (state == ISSUE);
   assign mem_op    = mem_en & op_r;
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {req_op, req_addr, req_wdata};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Every pop moves the FSM into ISSUE, so the popped entry is latched here.
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      lat_load   = 1'b0;
      rd_done    = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               next_state = ISSUE;
            end
         end
         ISSUE: begin
            if (op_r) begin
               if (!empty) begin
                  pop        = 1'b1;
                  next_state = ISSUE;
               end else begin
                  next_state = IDLE;
               end
            end else begin
               lat_load   = 1'b1;
               next_state = WAIT_RD;
            end
         end
         WAIT_RD: begin
            if (lat_cnt == '0) begin
               rd_done = 1'b1;
               if (!empty) begin
                  pop        = 1'b1;
                  next_state = ISSUE;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         op_r        <= 1'b0;
         mem_addr    <= '0;
         mem_data_in <= '0;
         lat_cnt     <= '0;
      end else begin
         state <= next_state;
         if (pop) begin
            op_r        <= head[EW-1];
            mem_addr    <= head[DATA_WIDTH +: ADDR_WIDTH];
            mem_data_in <= head[DATA_WIDTH-1:0];
         end
         if (lat_load) begin
            lat_cnt <= LW'(RD_LATENCY - 1);
         end else if (state == WAIT_RD && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
         end
      end
   end

   // mem_addr is still the read's address on the final WAIT_RD edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_valid <= 1'b0;
         rsp_addr  <= '0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= rd_done;
         if (rd_done) begin
            rsp_addr <= mem_addr;
            rsp_data <= mem_data_out;
         end
      end
   end

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Directed bench for mem_req_sequencer with a one-cycle-latency memory model
// attached to the issue bus.
module tb_mem_req_sequencer;

   localparam int DW = 8;
   localparam int AW = 4;

   logic          clk;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic          req_op;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          mem_en;
   logic          mem_op;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data_in;
   logic [DW-1:0] mem_data_out;
   logic          rsp_valid;
   logic [AW-1:0] rsp_addr;
   logic [DW-1:0] rsp_data;
   logic [2:0]    count;
   logic [1:0]    dbg_state;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [DW-1:0] mm [16];
   logic [12:0]   req_q[$];
   logic [12:0]   iss_q[$];
   int            iss_cyc_q[$];
   logic [11:0]   rsp_q[$];
   int            rsp_cyc_q[$];
   logic [2:0]    cnt_q[$];

   mem_req_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(4), .RD_LATENCY(1)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_en(mem_en), .mem_op(mem_op), .mem_addr(mem_addr),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
      .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
      .count(count), .dbg_state(dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      for (int i = 0; i < 16; i++) mm[i] = '0;
      mem_data_out = '0;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // memory model: write on issue, read data valid the cycle after issue
   always @(posedge clk) begin
      if (mem_en && mem_op) mm[mem_addr] <= mem_data_in;
      if (mem_en && !mem_op) mem_data_out <= mm[mem_addr];
   end

   // bus monitor
   always @(negedge clk) begin
      if (reset) begin
         if (mem_en) begin
            iss_q.push_back({mem_op, mem_addr, mem_data_in});
            iss_cyc_q.push_back(cyc);
         end
         if (rsp_valid) begin
            rsp_q.push_back({rsp_addr, rsp_data});
            rsp_cyc_q.push_back(cyc);
         end
         cnt_q.push_back(count);
      end
   end

   task automatic clear_logs();
      iss_q.delete();
      iss_cyc_q.delete();
      rsp_q.delete();
      rsp_cyc_q.delete();
      cnt_q.delete();
   endtask

   // driver: call at posedge+1; presents req_q entries in order, one per accepted edge
   task automatic run_pushes();
      for (int i = 0; i < req_q.size(); i++) begin
         logic acc;
         logic [12:0] r;
         r = req_q[i];
         acc = 1'b0;
         req_valid = 1'b1;
         req_op    = r[12];
         req_addr  = r[11:8];
         req_wdata = r[7:0];
         for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
         end
         checks++;
         if (!acc) begin
            failures++;
            $display("FAIL push_accept: entry %0d got ready=0 required ready=1", i);
         end
      end
      req_valid = 1'b0;
      req_q.delete();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %0b required 1", req_ready); end
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL rst_count: got %0d required 0", count); end
      checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL rst_mem_en: got %0b required 0", mem_en); end
      checks++; if (mem_op !== 1'b0) begin failures++; $display("FAIL rst_mem_op: got %0b required 0", mem_op); end
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid: got %0b required 0", rsp_valid); end
      checks++; if (mem_addr !== 4'h0) begin failures++; $display("FAIL rst_mem_addr: got %0h required 0", mem_addr); end
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single_write();
      clear_logs();
      req_q.push_back({1'b1, 4'h3, 8'hA5});
      run_pushes();
      @(negedge clk);
      checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL sw_early_en: got %0b required 0", mem_en); end
      checks++; if (count !== 3'd1) begin failures++; $display("FAIL sw_count1: got %0d required 1", count); end
      @(negedge clk);
      checks++; if ({mem_en, mem_op, mem_addr, mem_data_in} !== {1'b1, 1'b1, 4'h3, 8'hA5}) begin
         failures++; $display("FAIL sw_issue: got en=%0b op=%0b addr=%0h data=%0h required 1 1 3 a5", mem_en, mem_op, mem_addr, mem_data_in); end
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL sw_count0: got %0d required 0", count); end
      @(negedge clk);
      checks++; if ({mem_en, mem_op} !== 2'b00) begin failures++; $display("FAIL sw_one_cycle: got en=%0b op=%0b required 0 0", mem_en, mem_op); end
      checks++; if ({mem_addr, mem_data_in} !== {4'h3, 8'hA5}) begin failures++; $display("FAIL sw_hold: got %0h required 3a5", {mem_addr, mem_data_in}); end
      @(posedge clk);
      #1;
      checks++; if (iss_q.size() !== 1) begin failures++; $display("FAIL sw_issue_count: got %0d required 1", iss_q.size()); end
   endtask

   task automatic test_read_after_write();
      clear_logs();
      req_q.push_back({1'b1, 4'h5, 8'h3C});
      req_q.push_back({1'b0, 4'h5, 8'h00});
      run_pushes();
      repeat (8) @(posedge clk);
      #1;
      checks++; if (iss_q.size() !== 2) begin failures++; $display("FAIL raw_issues: got %0d required 2", iss_q.size()); end
      checks++; if (iss_q[0] !== {1'b1, 4'h5, 8'h3C}) begin failures++; $display("FAIL raw_wr_issue: got %0h required %0h", iss_q[0], {1'b1, 4'h5, 8'h3C}); end
      checks++; if (iss_q[1][12:8] !== {1'b0, 4'h5}) begin failures++; $display("FAIL raw_rd_issue: got %0h required 05", iss_q[1][12:8]); end
      checks++; if (iss_cyc_q[1] - iss_cyc_q[0] !== 1) begin failures++; $display("FAIL raw_b2b: got gap %0d required 1", iss_cyc_q[1] - iss_cyc_q[0]); end
      checks++; if (rsp_q.size() !== 1) begin failures++; $display("FAIL raw_rsp_count: got %0d required 1", rsp_q.size()); end
      checks++; if (rsp_q[0] !== {4'h5, 8'h3C}) begin failures++; $display("FAIL raw_rsp: got %0h required 53c", rsp_q[0]); end
      checks++; if (rsp_cyc_q[0] - iss_cyc_q[1] !== 2) begin failures++; $display("FAIL raw_latency: got %0d required 2", rsp_cyc_q[0] - iss_cyc_q[1]); end
      @(negedge clk);
      checks++; if ({rsp_valid, rsp_addr, rsp_data} !== {1'b0, 4'h5, 8'h3C}) begin
         failures++; $display("FAIL raw_rsp_hold: got v=%0b a=%0h d=%0h required 0 5 3c", rsp_valid, rsp_addr, rsp_data); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_full_fifo();
      logic [3:0] exp_a [7];
      logic [7:0] exp_d [4];
      exp_a = '{4'h5, 4'h3, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
      exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
      clear_logs();
      req_q.push_back({1'b0, 4'h5, 8'h00});
      req_q.push_back({1'b0, 4'h3, 8'h00});
      req_q.push_back({1'b0, 4'h5, 8'h00});
      for (int i = 0; i < 4; i++) req_q.push_back({1'b1, exp_a[3+i], exp_d[i]});
      run_pushes();
      @(negedge clk);
      checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count: got %0d required 4", count); end
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL full_ready: got %0b required 0", req_ready); end
      checks++; if (dbg_state !== 2'd2) begin failures++; $display("FAIL full_state: got %0d required 2", dbg_state); end
      req_valid = 1'b1; req_op = 1'b1; req_addr = 4'hC; req_wdata = 8'h55;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      checks++; if (count !== 3'd3) begin failures++; $display("FAIL full_no_bypass: got %0d required 3", count); end
      repeat (10) @(posedge clk);
      #1;
      checks++; if (iss_q.size() !== 7) begin failures++; $display("FAIL full_issues: got %0d required 7", iss_q.size()); end
      for (int i = 0; i < 7; i++) begin
         checks++; if (iss_q[i][11:8] !== exp_a[i]) begin failures++; $display("FAIL full_order: idx %0d got %0h required %0h", i, iss_q[i][11:8], exp_a[i]); end
      end
      for (int i = 0; i < 4; i++) begin
         checks++; if (iss_q[3+i] !== {1'b1, exp_a[3+i], exp_d[i]}) begin failures++; $display("FAIL full_wr: idx %0d got %0h required %0h", i, iss_q[3+i], {1'b1, exp_a[3+i], exp_d[i]}); end
      end
      for (int i = 4; i < 7; i++) begin
         checks++; if (iss_cyc_q[i] - iss_cyc_q[i-1] !== 1) begin failures++; $display("FAIL full_consec: idx %0d got gap %0d required 1", i, iss_cyc_q[i] - iss_cyc_q[i-1]); end
      end
      checks++; if (rsp_q.size() !== 3) begin failures++; $display("FAIL full_rsp_count: got %0d required 3", rsp_q.size()); end
      checks++; if ({rsp_q[0], rsp_q[1], rsp_q[2]} !== {4'h5, 8'h3C, 4'h3, 8'hA5, 4'h5, 8'h3C}) begin
         failures++; $display("FAIL full_rsp: got %0h %0h %0h required 53c 3a5 53c", rsp_q[0], rsp_q[1], rsp_q[2]); end
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL full_drain: got %0d required 0", count); end
   endtask

   task automatic test_push_pop_count2();
      logic [3:0] exp_a [5];
      exp_a = '{4'h6, 4'h1, 4'h2, 4'h4, 4'h7};
      clear_logs();
      req_q.push_back({1'b0, 4'h6, 8'h00});
      for (int i = 1; i < 5; i++) req_q.push_back({1'b1, exp_a[i], 8'h60 + 8'(exp_a[i])});
      run_pushes();
      repeat (8) @(posedge clk);
      #1;
      for (int k = 3; k < 6; k++) begin
         checks++; if (cnt_q[k] !== 3'd2) begin failures++; $display("FAIL pp_count: sample %0d got %0d required 2", k, cnt_q[k]); end
      end
      checks++; if (iss_q.size() !== 5) begin failures++; $display("FAIL pp_issues: got %0d required 5", iss_q.size()); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (iss_q[i][11:8] !== exp_a[i]) begin failures++; $display("FAIL pp_order: idx %0d got %0h required %0h", i, iss_q[i][11:8], exp_a[i]); end
      end
      checks++; if (iss_q[4] !== {1'b1, 4'h7, 8'h67}) begin failures++; $display("FAIL pp_last: got %0h required 1767", iss_q[4]); end
      checks++; if (rsp_q.size() !== 1 || rsp_q[0] !== {4'h6, 8'h00}) begin failures++; $display("FAIL pp_rsp: got n=%0d %0h required 1 600", rsp_q.size(), rsp_q[0]); end
   endtask

   task automatic test_reset_mid_read();
      clear_logs();
      req_q.push_back({1'b0, 4'h3, 8'h00});
      req_q.push_back({1'b1, 4'hD, 8'h0D});
      req_q.push_back({1'b1, 4'hE, 8'h0E});
      run_pushes();
      @(negedge clk);
      checks++; if (dbg_state !== 2'd2 || count !== 3'd2) begin failures++; $display("FAIL mr_pre: got state=%0d count=%0d required 2 2", dbg_state, count); end
      #2 reset = 1'b0;
      #1;
      checks++; if ({mem_en, mem_op, mem_addr, mem_data_in} !== 14'd0) begin
         failures++; $display("FAIL mr_mem_async: got en=%0b op=%0b a=%0h d=%0h required 0", mem_en, mem_op, mem_addr, mem_data_in); end
      checks++; if ({rsp_valid, rsp_addr, rsp_data} !== 13'd0) begin
         failures++; $display("FAIL mr_rsp_async: got v=%0b a=%0h d=%0h required 0", rsp_valid, rsp_addr, rsp_data); end
      checks++; if (count !== 3'd0 || req_ready !== 1'b1 || dbg_state !== 2'd0) begin
         failures++; $display("FAIL mr_fifo_async: got count=%0d ready=%0b state=%0d required 0 1 0", count, req_ready, dbg_state); end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      clear_logs();
      repeat (6) @(posedge clk);
      #1;
      checks++; if (rsp_q.size() !== 0) begin failures++; $display("FAIL mr_no_rsp: got %0d required 0", rsp_q.size()); end
      checks++; if (iss_q.size() !== 0) begin failures++; $display("FAIL mr_no_issue: got %0d required 0", iss_q.size()); end
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL mr_empty: got %0d required 0", count); end
   endtask

   initial begin
      req_valid = 1'b0;
      req_op    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      test_reset();
      test_single_write();
      test_read_after_write();
      test_full_fifo();
      test_push_pop_count2();
      test_reset_mid_read();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
